// File: rtl/alert_annunciator_pkg.sv
// Shared types and defaults for the alert annunciator.
// State encodings, default timing constants and the timer width helper.
package alert_annunciator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALARM    = 2'd1,
    ST_SILENCED = 2'd2
  } state_t;

  localparam int BLINK_DIV_DEF   = 5;
  localparam int SILENCE_CYC_DEF = 20;
  localparam int CNT_W_DEF       = 8;

  function automatic int tmr_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Load/count/terminal-flag counter used for blink and silence timing.
// Counts up from zero and reloads to zero on reaching term.
module alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = (cnt == term);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (en)
      cnt <= done ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/alert_annunciator.sv
// Alert annunciator: buzzer/LED driver with acknowledge and silence.
// Define ALARM_AUTOCLEAR_EN to let ALARM self-clear after a quiet window.
import alert_annunciator_pkg::*;

module alert_annunciator #(
  parameter int BLINK_DIV   = BLINK_DIV_DEF,
  parameter int SILENCE_CYC = SILENCE_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alert_q,
  input  logic             ack,
  output logic             buzzer,
  output logic             led,
  output logic             alarm_active,
  output logic [CNT_W-1:0] event_count
);

  localparam int TW = tmr_w(BLINK_DIV, SILENCE_CYC);
  localparam logic [TW-1:0] BLK_TERM = TW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] SIL_TERM = TW'(SILENCE_CYC - 1);

  state_t           st;
  state_t           nxt;
  logic             blk_load;
  logic             blk_en;
  logic             blk_done;
  logic             sil_load;
  logic             sil_en;
  logic             sil_done;
  logic             led_d;
  logic [CNT_W-1:0] cnt_d;

  alarm_timer #(.W(TW)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .load (blk_load),
    .en   (blk_en),
    .term (BLK_TERM),
    .done (blk_done)
  );

  alarm_timer #(.W(TW)) u_silence (
    .clk  (clk),
    .rst  (rst),
    .load (sil_load),
    .en   (sil_en),
    .term (SIL_TERM),
    .done (sil_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= ST_IDLE;
      buzzer       <= 1'b0;
      led          <= 1'b0;
      alarm_active <= 1'b0;
      event_count  <= '0;
    end else begin
      st           <= nxt;
      buzzer       <= (nxt == ST_ALARM);
      led          <= led_d;
      alarm_active <= (nxt != ST_IDLE);
      event_count  <= cnt_d;
    end
  end

  always_comb begin
    nxt = st;
    unique case (1'b1)
      st == ST_IDLE: begin
        if (alert_q) nxt = ST_ALARM;
      end
      st == ST_ALARM: begin
        if (ack)
          nxt = alert_q ? ST_SILENCED : ST_IDLE;
`ifdef ALARM_AUTOCLEAR_EN
        else if (!alert_q && sil_done)
          nxt = ST_IDLE;
`endif
      end
      st == ST_SILENCED: begin
        // a cleared alert wins over timer expiry
        if (!alert_q)
          nxt = ST_IDLE;
        else if (!ack && sil_done)
          nxt = ST_ALARM;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    blk_load = (nxt == ST_ALARM) && (st != ST_ALARM);
    blk_en   = (nxt == ST_ALARM) && (st == ST_ALARM);
    sil_load = (nxt != st) || ack ||
               ((st == ST_ALARM) && alert_q);
`ifdef ALARM_AUTOCLEAR_EN
    sil_en   = (st != ST_IDLE);
`else
    sil_en   = (st == ST_SILENCED);
`endif
    led_d = 1'b0;
    if (nxt == ST_ALARM)
      led_d = blk_load ? 1'b1 : (blk_done ? ~led : led);
    else if (nxt == ST_SILENCED)
      led_d = 1'b1;
    cnt_d = event_count;
    if (blk_load && (event_count != '1))
      cnt_d = event_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_alert_annunciator.sv
// Scoreboard bench for alert_annunciator (default and 2-bit counter).
// Stimulus pushes expected outputs; a monitor pops after each edge.
module tb_alert_annunciator;

  logic       clk;
  logic       rst;
  logic       alert_q;
  logic       ack;
  logic       buz8, led8, act8;
  logic [7:0] cnt8;
  logic       buz2, led2, act2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic buz;
    logic led;
    logic act;
    int   cnt;
  } exp_t;

  exp_t sb[$];

  alert_annunciator u8 (
    .clk          (clk),
    .rst          (rst),
    .alert_q      (alert_q),
    .ack          (ack),
    .buzzer       (buz8),
    .led          (led8),
    .alarm_active (act8),
    .event_count  (cnt8)
  );

  alert_annunciator #(.CNT_W(2)) u2 (
    .clk          (clk),
    .rst          (rst),
    .alert_q      (alert_q),
    .ack          (ack),
    .buzzer       (buz2),
    .led          (led2),
    .alarm_active (act2),
    .event_count  (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic k,
                      input logic eb, input logic el, input logic ea,
                      input int ec);
    exp_t x;
    @(negedge clk);
    rst     = r;
    alert_q = a;
    ack     = k;
    x.buz = eb;
    x.led = el;
    x.act = ea;
    x.cnt = ec;
    sb.push_back(x);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("buzzer", {31'd0, buz8}, {31'd0, e.buz});
        chk("led", {31'd0, led8}, {31'd0, e.led});
        chk("alarm_active", {31'd0, act8}, {31'd0, e.act});
        chk("event_count", {24'd0, cnt8}, e.cnt);
        chk("event_count_w2", {30'd0, cnt2},
            (e.cnt > 3) ? 3 : e.cnt);
        chk("led_w2", {31'd0, led2}, {31'd0, e.led});
      end
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    alert_q = 1'b1;
    ack = 1'b0;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 1, 1);
    for (int i = 1; i < 30; i++)
      step(1, 1, 0, 1, ((i / 5) % 2) == 0, 1, 1);
    step(1, 1, 1, 0, 1, 1, 1);
    for (int j = 1; j < 20; j++)
      step(1, 1, 0, 0, 1, 1, 1);
    step(1, 1, 0, 1, 1, 1, 2);
    step(1, 1, 1, 0, 1, 1, 2);
    for (int j = 1; j < 10; j++)
      step(1, 1, 0, 0, 1, 1, 2);
    step(1, 1, 1, 0, 1, 1, 2);
    for (int j = 11; j < 30; j++)
      step(1, 1, 0, 0, 1, 1, 2);
    step(1, 1, 0, 1, 1, 1, 3);
    step(1, 1, 1, 0, 1, 1, 3);
    for (int j = 0; j < 3; j++)
      step(1, 1, 0, 0, 1, 1, 3);
    step(1, 0, 0, 0, 0, 0, 3);
    step(1, 0, 1, 0, 0, 0, 3);
    step(1, 1, 1, 1, 1, 1, 4);
    for (int i = 1; i <= 50; i++) begin
`ifdef ALARM_AUTOCLEAR_EN
      if (i < 20)
        step(1, 0, 0, 1, ((i / 5) % 2) == 0, 1, 4);
      else
        step(1, 0, 0, 0, 0, 0, 4);
`else
      step(1, 0, 0, 1, ((i / 5) % 2) == 0, 1, 4);
`endif
    end
    step(1, 0, 1, 0, 0, 0, 4);
    for (int n = 5; n <= 6; n++) begin
      step(1, 1, 0, 1, 1, 1, n);
      step(1, 0, 1, 0, 0, 0, n);
    end
    step(1, 1, 0, 1, 1, 1, 7);
    step(1, 1, 0, 1, 1, 1, 7);
    step(0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("rst_buzzer", {31'd0, buz8}, 0);
    chk("rst_led", {31'd0, led8}, 0);
    chk("rst_active", {31'd0, act8}, 0);
    chk("rst_count", {24'd0, cnt8}, 0);
    chk("rst_count_w2", {30'd0, cnt2}, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 10 && sb.size() > 0; t++)
      @(posedge clk);
    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
